shift_register_univ: RTL and testbench
======================================

Name: shift_register_univ

Overview:
- Parametrised successor to the plain D register: WIDTH-bit register with mode-selected hold, load, shift, rotate and synchronous clear.
- Adds a built-in serialiser: one start pulse loads D and shifts it out MSB-first over WIDTH cycles, with busy/done handshake.
- Used as a general-purpose data register and as a parallel-to-serial front end in sequential-circuit designs.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- RESET_VAL, {WIDTH{1'b0}}, value loaded by async reset and by the sync-clear mode.
- CNT_W, $clog2(WIDTH), width of the internal serialiser bit counter (localparam, derived).

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous reset, active-low; clr=0 forces reset state immediately.
- en  input  1  mode-operation enable; en=0 means hold when idle.
- mode  input  3  operation select, sampled when en=1 and busy=0.
- D  input  WIDTH  parallel data for load and serialise.
- ser_in  input  1  fill bit for shifts and serialiser.
- start  input  1  serialise request, sampled when busy=0.
- Q  output  WIDTH  registered contents.
- sout  output  1  serial out = Q[WIDTH-1] (combinational from Q).
- busy  output  1  high while serialising.
- done  output  1  one-cycle pulse on serialise completion.

Behaviour:
- Reset (clr=0, async): Q=RESET_VAL, busy=0, done=0, counter=0. Applies mid-serialise and aborts it; no done pulse.
- done defaults to 0 every edge unless set by the completion rule.
- Idle priority (busy=0): start=1 beats en/mode; else en=1 applies mode; else hold.
- Modes, all taking effect at the next rising edge:
  - 000 hold.
  - 001 load: Q<=D.
  - 010 shift left: Q<={Q[W-2:0],ser_in}.
  - 011 logical shift right: Q<={ser_in,Q[W-1:1]}.
  - 100 rotate left: Q<={Q[W-2:0],Q[W-1]}.
  - 101 rotate right: Q<={Q[0],Q[W-1:1]}.
  - 110 arithmetic shift right: Q<={Q[W-1],Q[W-1:1]}.
  - 111 sync clear: Q<=RESET_VAL.
- Serialise start edge: Q<=D, counter<=WIDTH-1, busy<=1.
- Each edge with busy=1: Q shifts left, filling with ser_in.
  - If counter!=0: counter decrements.
  - If counter==0: busy<=0 and done<=1 on the same edge.
- Busy duration and output timing:
  - busy is high for exactly WIDTH cycles.
  - During those cycles sout presents D[W-1], D[W-2], ..., D[0], one bit per cycle.
  - After completion Q holds the WIDTH ser_in bits shifted in during busy.
- While busy=1: en, mode and start are ignored.
- start held high at completion: the first idle edge (the edge after done) starts a new serialise. Back-to-back throughput is WIDTH+1 cycles per word.
- No latency beyond one clock for any mode. Q only changes on clk rising edge or clr assertion.

Test Plan:
- Reset: clr=0 with Q=8'hFF mid-cycle -> Q=8'h00, busy=0, done=0 immediately, before any clock edge. Release clr -> Q stays 8'h00 while en=0.
- Load and shifts (WIDTH=8): load 8'b10101001 (mode 001).
  - Mode 010 with ser_in=1 -> 8'b01010011.
  - Mode 110 -> 8'b00101001.
  - Reload, mode 101 -> 8'b11010100.
  - Reload, mode 100 -> 8'b01010011.
  - Mode 111 -> 8'h00.
- Hold: en=0 with mode=010 toggling for 5 cycles -> Q unchanged.
- Serialise: D=8'hA9, start pulse, ser_in=0 -> busy high 8 cycles; sout=1,0,1,0,1,0,0,1; done pulses exactly once on the edge busy falls; final Q=8'h00.
- Busy masking and priority:
  - During serialise, drive start=1, en=1, mode=111 -> stream unaffected.
  - Idle with start=1, en=1, mode=011 -> serialise wins, Q=D.
- Abort: clr=0 in busy cycle 4 -> busy=0, done never pulses. After release, a new start with D=8'hFF -> eight 1s on sout.

Source files
------------

// File: rtl/shift_register_univ.sv
// rtl/shift_register_univ.sv - universal shift register with built-in MSB-first serialiser
module shift_register_univ #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             ser_in,
    input  logic             start,
    output logic [WIDTH-1:0] Q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_t;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mode_next;

    always_comb begin
        mode_next = Q;
        case (mode_t'(mode))
            MODE_HOLD:  mode_next = Q;
            MODE_LOAD:  mode_next = D;
            MODE_SHL:   mode_next = {Q[WIDTH-2:0], ser_in};
            MODE_SHR:   mode_next = {ser_in, Q[WIDTH-1:1]};
            MODE_ROL:   mode_next = {Q[WIDTH-2:0], Q[WIDTH-1]};
            MODE_ROR:   mode_next = {Q[0], Q[WIDTH-1:1]};
            MODE_ASR:   mode_next = {Q[WIDTH-1], Q[WIDTH-1:1]};
            MODE_CLEAR: mode_next = RESET_VAL;
            default:    mode_next = Q;
        endcase
    end

    // Busy dominates everything; when idle, start beats the mode operation.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            Q    <= RESET_VAL;
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                Q <= {Q[WIDTH-2:0], ser_in};
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end else begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (start) begin
                Q    <= D;
                cnt  <= CNT_W'(WIDTH - 1);
                busy <= 1'b1;
            end else if (en) begin
                Q <= mode_next;
            end
        end
    end

    assign sout = Q[WIDTH-1];

endmodule

// File: tb/tb_shift_register_univ.sv
// tb/tb_shift_register_univ.sv - scoreboard bench for shift_register_univ (WIDTH=8)
module tb_shift_register_univ;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [7:0] D = 8'h00;
    logic       ser_in = 1'b0;
    logic       start = 1'b0;
    logic [7:0] Q;
    logic       sout, busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       b;
        logic       d;
    } exp_t;

    exp_t sb[$];

    shift_register_univ #(.WIDTH(8)) dut (
        .clk(clk), .clr(clr), .en(en), .mode(mode), .D(D), .ser_in(ser_in),
        .start(start), .Q(Q), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [2:0] m, input logic s,
                         input logic [7:0] d, input logic si);
        en = e; mode = m; start = s; D = d; ser_in = si;
    endtask

    // Push the expectation for the coming edge, clock it, then pop and compare.
    task automatic step(input string tag, input logic [7:0] q, input logic b, input logic d);
        exp_t e;
        e.tag = tag; e.q = q; e.b = b; e.d = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_q"}, {24'd0, Q}, {24'd0, e.q});
            check({e.tag, "_sout"}, {31'd0, sout}, {31'd0, e.q[7]});
            check({e.tag, "_busy"}, {31'd0, busy}, {31'd0, e.b});
            check({e.tag, "_done"}, {31'd0, done}, {31'd0, e.d});
        end
    endtask

    // Runs the remaining busy edges after the start edge; ser_in held at fill.
    task automatic serial_tail(input string tag, input logic [7:0] first, input logic fill);
        logic [7:0] q;
        q = first;
        for (int k = 1; k <= 8; k++) begin
            q = {q[6:0], fill};
            step($sformatf("%s_b%0d", tag, k), q, (k < 8), (k == 8));
        end
    endtask

    initial begin
        #1;
        check("rst_q", {24'd0, Q}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);

        clr = 1'b1;
        drive(1'b1, 3'b001, 1'b0, 8'hFF, 1'b0);
        step("ld_ff", 8'hFF, 1'b0, 1'b0);
        #2 clr = 1'b0;
        #1;
        check("async_q", {24'd0, Q}, 32'h00);
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_done", {31'd0, done}, 32'd0);
        clr = 1'b1;
        drive(1'b0, 3'b001, 1'b0, 8'hFF, 1'b0);
        step("rel0", 8'h00, 1'b0, 1'b0);
        step("rel1", 8'h00, 1'b0, 1'b0);

        drive(1'b1, 3'b001, 1'b0, 8'hA9, 1'b1);
        step("load", 8'hA9, 1'b0, 1'b0);
        drive(1'b1, 3'b010, 1'b0, 8'hA9, 1'b1);
        step("shl", 8'h53, 1'b0, 1'b0);
        drive(1'b1, 3'b110, 1'b0, 8'hA9, 1'b1);
        step("asr", 8'h29, 1'b0, 1'b0);
        drive(1'b1, 3'b001, 1'b0, 8'hA9, 1'b0);
        step("reload1", 8'hA9, 1'b0, 1'b0);
        drive(1'b1, 3'b101, 1'b0, 8'hA9, 1'b0);
        step("ror", 8'hD4, 1'b0, 1'b0);
        drive(1'b1, 3'b001, 1'b0, 8'hA9, 1'b0);
        step("reload2", 8'hA9, 1'b0, 1'b0);
        drive(1'b1, 3'b100, 1'b0, 8'hA9, 1'b0);
        step("rol", 8'h53, 1'b0, 1'b0);
        drive(1'b1, 3'b011, 1'b0, 8'hA9, 1'b1);
        step("shr", 8'hA9, 1'b0, 1'b0);
        drive(1'b1, 3'b000, 1'b0, 8'h00, 1'b0);
        step("hold_mode", 8'hA9, 1'b0, 1'b0);
        drive(1'b1, 3'b111, 1'b0, 8'hA9, 1'b0);
        step("sclr", 8'h00, 1'b0, 1'b0);

        drive(1'b1, 3'b001, 1'b0, 8'hA9, 1'b0);
        step("reload3", 8'hA9, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, (i % 2 == 0) ? 3'b010 : 3'b111, 1'b0, 8'h00, 1'b1);
            step($sformatf("en0_hold%0d", i), 8'hA9, 1'b0, 1'b0);
        end

        drive(1'b0, 3'b000, 1'b1, 8'hA9, 1'b0);
        step("ser_start", 8'hA9, 1'b1, 1'b0);
        start = 1'b0;
        serial_tail("ser", 8'hA9, 1'b0);
        step("ser_after", 8'h00, 1'b0, 1'b0);

        drive(1'b0, 3'b000, 1'b1, 8'hA9, 1'b1);
        step("mask_start", 8'hA9, 1'b1, 1'b0);
        drive(1'b1, 3'b111, 1'b1, 8'h3C, 1'b1);
        serial_tail("mask", 8'hA9, 1'b1);
        step("b2b_start", 8'h3C, 1'b1, 1'b0);
        drive(1'b0, 3'b000, 1'b0, 8'h00, 1'b0);
        serial_tail("b2b", 8'h3C, 1'b0);

        drive(1'b1, 3'b011, 1'b1, 8'h5A, 1'b1);
        step("prio_start", 8'h5A, 1'b1, 1'b0);
        drive(1'b0, 3'b000, 1'b0, 8'h00, 1'b1);
        serial_tail("prio", 8'h5A, 1'b1);

        drive(1'b0, 3'b000, 1'b1, 8'hA9, 1'b0);
        step("abort_start", 8'hA9, 1'b1, 1'b0);
        start = 1'b0;
        step("abort_b1", 8'h52, 1'b1, 1'b0);
        step("abort_b2", 8'hA4, 1'b1, 1'b0);
        step("abort_b3", 8'h48, 1'b1, 1'b0);
        #2 clr = 1'b0;
        #1;
        check("abort_q", {24'd0, Q}, 32'h00);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        clr = 1'b1;
        for (int i = 0; i < 9; i++) step($sformatf("abort_idle%0d", i), 8'h00, 1'b0, 1'b0);

        drive(1'b0, 3'b000, 1'b1, 8'hFF, 1'b0);
        step("ff_start", 8'hFF, 1'b1, 1'b0);
        start = 1'b0;
        serial_tail("ff", 8'hFF, 1'b0);

        check("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
